fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage pipeline. It owns the PC, issues requests over a variable-latency instruction-memory handshake, and fills the IF/ID pipeline register. It consumes PC_write and IFID_write from hazard detection, and the branch redirect/flush from the resolving stage. It feeds IF/ID pc, instruction and valid fields to decode and hazard detection.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble instruction placed in IF/ID
ADDR_W, 32, PC/address width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
PC_write  in  1  hazard unit: 0 = hold PC
IFID_write  in  1  hazard unit: 0 = hold IF/ID
branch_taken  in  1  redirect request; also flushes IF/ID
branch_target  in  ADDR_W  redirect address
imem_req  out  1  instruction fetch request
imem_addr  out  ADDR_W  fetch address, equals PC
imem_ack  in  1  read data valid this cycle
imem_rdata  in  32  instruction word
IFID_pc  out  ADDR_W  PC of instruction in IF/ID
IFID_pc4  out  ADDR_W  IFID_pc + 4
IFID_instr  out  32  instruction in IF/ID
IFID_valid  out  1  1 = real instruction, 0 = bubble
fetch_busy  out  1  1 while in state FETCH without ack, or in DRAIN

Behaviour:
- Reset (async, rst_i=0):
  - pc=RESET_PC; state=FETCH; hold buffer empty.
  - IFID_pc=0, IFID_instr=NOP_INSTR, IFID_valid=0.
  - imem_req is 1 right after reset release.
- stall = !PC_write || !IFID_write.
- States:
  - FETCH:
    - imem_req=1, imem_addr=pc; address stays stable until ack.
    - Ack and !stall: IF/ID <= {pc, rdata, valid=1}; pc <= pc+4; stay in FETCH. A new request goes out the next cycle. Zero-wait ack in the request cycle is allowed.
    - Ack and stall: capture rdata and pc into the hold buffer; go to HOLD. IF/ID is unchanged.
    - No ack and IFID_write=1: IF/ID <= bubble (NOP_INSTR, valid=0).
    - No ack and IFID_write=0: IF/ID holds.
  - HOLD:
    - imem_req=0.
    - While stall: IF/ID and buffer hold.
    - On !stall: IF/ID <= buffer (valid=1); pc <= pc+4; go to FETCH.
  - DRAIN:
    - imem_req=0; the outstanding request is still in memory.
    - The next ack is discarded; then go to FETCH at the redirected pc.
    - IF/ID loads bubbles while IFID_write=1.
- Redirect has highest priority and overrides stall:
  - pc <= branch_target; IF/ID <= bubble regardless of IFID_write; hold buffer discarded.
  - FETCH with no ack this cycle (request outstanding) -> DRAIN.
  - FETCH with ack this cycle -> data dropped, go to FETCH.
  - HOLD -> FETCH.
  - DRAIN with ack this cycle -> FETCH.
  - DRAIN with no ack -> stay in DRAIN with the new pc.
- PC arithmetic: pc+4 modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0. IFID_pc4 = IFID_pc+4, same wrap.
- Ack outside FETCH/DRAIN is a protocol error and is ignored.
- Reset mid-request returns to FETCH at RESET_PC. Memory must abandon the old request on reset.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds output ports perf_fetched (32) and perf_stall_cycles (32), both reset to 0.
  - perf_fetched increments on each IF/ID load with valid=1.
  - perf_stall_cycles increments every cycle that stall=1 or fetch_busy=1.
  - Both wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, zero-wait memory (ack same cycle), no stalls, 4 cycles -> IFID_pc = 0,4,8,12 with valid=1; imem_addr leads IFID_pc by one cycle.
- Memory latency 3 cycles -> IFID_valid=0 with NOP_INSTR for 2 cycles, then IFID_pc=0 valid=1; fetch_busy=1 during the wait.
- Ack at pc=8 while PC_write=IFID_write=0 for 3 cycles -> state HOLD, imem_req=0, IF/ID unchanged; on release IFID_pc=8 valid=1 and next imem_addr=12.
- branch_taken with target 0x100 while a request to 0x10 is outstanding -> IF/ID bubble, DRAIN; late ack for 0x10 discarded; next imem_addr=0x100 and IFID_pc=0x100 thereafter.
- branch_taken in the same cycle as ack and stall -> ack data dropped, no HOLD, next request to target; pc=32'hFFFF_FFFC fetched -> next imem_addr=0.
- rst_i low mid-request, and with FETCH_PERF_EN after 5 stalls -> outputs return to reset values asynchronously; perf_stall_cycles counts 5 before reset and is cleared to 0 by it.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bundle between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if #(
   parameter int ADDR_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [31:0]       imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the variable-latency imem handshake
// and fills IF/ID. Define FETCH_PERF_EN to add the perf_fetched/perf_stall_cycles counters.
module fetch_stage #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              PC_write,
   input  logic              IFID_write,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   fetch_stage_if.master     imem,
   output logic [ADDR_W-1:0] IFID_pc,
   output logic [ADDR_W-1:0] IFID_pc4,
   output logic [31:0]       IFID_instr,
   output logic              IFID_valid,
`ifdef FETCH_PERF_EN
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_stall_cycles,
`endif
   output logic              fetch_busy
);

   localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);

   typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN} state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_pc, w_pc_nxt;
   logic [ADDR_W-1:0] r_hold_pc, w_hold_pc_nxt;
   logic [31:0]       r_hold_instr, w_hold_instr_nxt;
   logic [ADDR_W-1:0] r_ifid_pc, w_ifid_pc_nxt;
   logic [31:0]       r_ifid_instr, w_ifid_instr_nxt;
   logic              r_ifid_valid, w_ifid_valid_nxt;
   logic              w_stall;
   logic              w_load_valid;

   assign w_stall         = !PC_write || !IFID_write;
   assign imem.imem_req   = (r_state == S_FETCH);
   assign imem.imem_addr  = r_pc;
   assign fetch_busy      = ((r_state == S_FETCH) && !imem.imem_ack) || (r_state == S_DRAIN);
   assign IFID_pc         = r_ifid_pc;
   assign IFID_pc4        = r_ifid_pc + PC_INC;
   assign IFID_instr      = r_ifid_instr;
   assign IFID_valid      = r_ifid_valid;

   // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_hold_pc_nxt    = r_hold_pc;
      w_hold_instr_nxt = r_hold_instr;
      w_ifid_pc_nxt    = r_ifid_pc;
      w_ifid_instr_nxt = r_ifid_instr;
      w_ifid_valid_nxt = r_ifid_valid;
      w_load_valid     = 1'b0;

      if (branch_taken) begin
         // Redirect beats stall; an outstanding request must be drained before refetching.
         w_pc_nxt         = branch_target;
         w_ifid_instr_nxt = NOP_INSTR;
         w_ifid_valid_nxt = 1'b0;
         case (r_state)
            S_FETCH: w_state_nxt = imem.imem_ack ? S_FETCH : S_DRAIN;
            S_DRAIN: w_state_nxt = imem.imem_ack ? S_FETCH : S_DRAIN;
            default: w_state_nxt = S_FETCH;
         endcase
      end else begin
         case (r_state)
            S_FETCH: begin
               if (imem.imem_ack && !w_stall) begin
                  w_ifid_pc_nxt    = r_pc;
                  w_ifid_instr_nxt = imem.imem_rdata;
                  w_ifid_valid_nxt = 1'b1;
                  w_load_valid     = 1'b1;
                  w_pc_nxt         = r_pc + PC_INC;
               end else if (imem.imem_ack) begin
                  w_hold_pc_nxt    = r_pc;
                  w_hold_instr_nxt = imem.imem_rdata;
                  w_state_nxt      = S_HOLD;
               end else if (IFID_write) begin
                  w_ifid_instr_nxt = NOP_INSTR;
                  w_ifid_valid_nxt = 1'b0;
               end
            end
            S_HOLD: begin
               if (!w_stall) begin
                  w_ifid_pc_nxt    = r_hold_pc;
                  w_ifid_instr_nxt = r_hold_instr;
                  w_ifid_valid_nxt = 1'b1;
                  w_load_valid     = 1'b1;
                  w_pc_nxt         = r_pc + PC_INC;
                  w_state_nxt      = S_FETCH;
               end
            end
            S_DRAIN: begin
               if (imem.imem_ack) w_state_nxt = S_FETCH;
               if (IFID_write) begin
                  w_ifid_instr_nxt = NOP_INSTR;
                  w_ifid_valid_nxt = 1'b0;
               end
            end
            default: w_state_nxt = S_FETCH;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state      <= S_FETCH;
         r_pc         <= RESET_PC;
         r_hold_pc    <= '0;
         r_hold_instr <= '0;
         r_ifid_pc    <= '0;
         r_ifid_instr <= NOP_INSTR;
         r_ifid_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_hold_pc    <= w_hold_pc_nxt;
         r_hold_instr <= w_hold_instr_nxt;
         r_ifid_pc    <= w_ifid_pc_nxt;
         r_ifid_instr <= w_ifid_instr_nxt;
         r_ifid_valid <= w_ifid_valid_nxt;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] r_perf_fetched, r_perf_stall;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_perf_fetched <= '0;
         r_perf_stall   <= '0;
      end else begin
         if (w_load_valid)           r_perf_fetched <= r_perf_fetched + 32'd1;
         if (w_stall || fetch_busy)  r_perf_stall   <= r_perf_stall + 32'd1;
      end
   end

   assign perf_fetched      = r_perf_fetched;
   assign perf_stall_cycles = r_perf_stall;
`else
   logic w_unused_load;
   assign w_unused_load = w_load_valid;
`endif

endmodule
